// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
// Consumers: clk_div_edge_det and clk_div_monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } clk_mon_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_TIMEOUT     = 1024;

    // Bits needed to hold a run length of 0..n.
    function automatic int run_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// Samples the divided clock and produces registered rise/fall ticks in the clk domain.
// Optional synchronizer enabled by defining CLK_MON_SYNC_EN.
module clk_div_edge_det
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clk_div_in,
    output logic rise_det,
    output logic tick_rise,
    output logic tick_fall
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("clk_div_edge_det: SYNC_STAGES must be at least 2");
    end

    logic s;
    logic s_prev;
    logic fall_det;

`ifdef CLK_MON_SYNC_EN
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], clk_div_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];
`else
    // Input is already a clk-domain flop output, so it is used as-is.
    assign s = clk_div_in;
`endif

    assign rise_det = s & ~s_prev;
    assign fall_det = ~s & s_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_prev    <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            s_prev    <= s;
            tick_rise <= rise_det;
            tick_fall <= fall_det;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: edge ticks, period measurement, lock and loss detection.
// Define CLK_MON_SYNC_EN when clk_div_in is asynchronous to clk.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clk_div_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             clk_lost
);

    localparam int RUN_W = run_width(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_COUNT);

    if (LOCK_COUNT < 1) begin : g_bad_lock_count
        $error("clk_div_monitor: LOCK_COUNT must be at least 1");
    end
    if (TIMEOUT < 2 || (longint'(TIMEOUT) >> CNT_W) != 0) begin : g_bad_timeout
        $error("clk_div_monitor: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
    end

    logic rise_det;

    clk_div_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_det (
        .clk        (clk),
        .resetn     (resetn),
        .clk_div_in (clk_div_in),
        .rise_det   (rise_det),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall)
    );

    logic [CNT_W-1:0] cnt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic [RUN_W-1:0] run_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             valid_nxt;
    logic             timeout;
    clk_mon_state_t   state;
    clk_mon_state_t   state_nxt;

    // cnt is the number of clk cycles since the last detected rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (rise_det) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A rise on the timeout cycle wins over the timeout.
    assign timeout = (cnt == TIMEOUT_C) && !rise_det;
    assign run_inc = run + RUN_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        valid_nxt  = period_valid;
        run_nxt    = run;
        case (state)
            IDLE: begin
                if (rise_det) begin
                    state_nxt = MEASURE;
                    run_nxt   = '0;
                end else if (timeout) begin
                    state_nxt = LOST;
                    valid_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (rise_det) begin
                    period_nxt = cnt;
                    valid_nxt  = 1'b1;
                    run_nxt    = (period_valid && cnt == period) ? run_inc : RUN_W'(1);
                    if (run_nxt == LOCK_C) begin
                        state_nxt = LOCKED;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    valid_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if (rise_det) begin
                    if (cnt != period) begin
                        period_nxt = cnt;
                        run_nxt    = RUN_W'(1);
                        state_nxt  = MEASURE;
                    end
                end else if (timeout) begin
                    state_nxt = LOST;
                    valid_nxt = 1'b0;
                end
            end
            LOST: begin
                if (rise_det) begin
                    state_nxt = MEASURE;
                    run_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period       <= '0;
            period_valid <= 1'b0;
            run          <= '0;
        end else begin
            period       <= period_nxt;
            period_valid <= valid_nxt;
            run          <= run_nxt;
        end
    end

    assign locked   = (state == LOCKED);
    assign clk_lost = (state == LOST);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor; expected tick latency follows CLK_MON_SYNC_EN.
`timescale 1ns/1ps
module tb_clk_div_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;
    localparam int LOCK_COUNT  = 4;
    localparam int TIMEOUT     = 64;
`ifdef CLK_MON_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    logic             clk;
    logic             resetn;
    logic             clk_div_in;
    logic             tick_rise;
    logic             tick_fall;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             clk_lost;

    clk_div_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .LOCK_COUNT  (LOCK_COUNT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .clk_div_in   (clk_div_in),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .clk_lost     (clk_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Divided-clock generator: full period is 2*half, half changes only at a rising input.
    bit drive_en  = 1'b0;
    bit stop_low  = 1'b0;
    int half      = 2;
    int half_next = 2;
    int ph        = 0;

    initial begin
        clk_div_in = 1'b0;
        forever begin
            @(negedge clk);
            if (drive_en) begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    if (clk_div_in) begin
                        clk_div_in = 1'b0;
                    end else if (!stop_low) begin
                        half       = half_next;
                        clk_div_in = 1'b1;
                    end
                end
            end
        end
    end

    // Reference model: works from the input samples and the rules on rise distances.
    logic [7:0] hist;
    int  edge_n = 0;
    int  dut_last_rise = 0;
    int  in_rise_edge = 0;
    int  since, m_period, nmeas, streak;
    bit  started, m_lost, m_rise, m_fall;

    initial begin
        hist = '0; since = 0; m_period = 0; nmeas = 0; streak = 0;
        started = 0; m_lost = 0; m_rise = 0; m_fall = 0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!resetn) begin
                hist = '0; since = 0; m_period = 0; nmeas = 0; streak = 0;
                started = 0; m_lost = 0; m_rise = 0; m_fall = 0;
            end else begin
                hist   = {hist[6:0], clk_div_in};
                m_rise = hist[LAT] & ~hist[LAT+1];
                m_fall = ~hist[LAT] & hist[LAT+1];
                if (hist[0] & ~hist[1]) in_rise_edge = edge_n;
                if (m_rise) begin
                    if (started) begin
                        if (nmeas > 0 && since == m_period) streak++;
                        else streak = 1;
                        m_period = since;
                        nmeas++;
                    end
                    started = 1;
                    m_lost  = 0;
                    since   = 1;
                end else begin
                    if (!m_lost && since == TIMEOUT) begin
                        m_lost = 1; started = 0; nmeas = 0; streak = 0;
                    end
                    if (since < (1 << 20)) since++;
                end
            end
            #1;
            if (tick_rise) dut_last_rise = edge_n;
            chk("tick_rise", 32'(tick_rise), 32'(m_rise));
            chk("tick_fall", 32'(tick_fall), 32'(m_fall));
            chk("period", 32'(period), 32'(m_period));
            chk("period_valid", 32'(period_valid), 32'(nmeas > 0));
            chk("locked", 32'(locked), 32'(started && streak >= LOCK_COUNT));
            chk("clk_lost", 32'(clk_lost), 32'(m_lost));
        end
    end

    task automatic wait_rise();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #2;
            got = tick_rise;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_rise: no tick_rise within 200 cycles at %0t", $time);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        resetn = 1'b0;
        half = 2; half_next = 2; drive_en = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Asynchronous reset mid-cycle while measuring.
        wait_rise();
        wait_rise();
        chk("pre_rst_valid", 32'(period_valid), 32'd1);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("rst_tick_rise", 32'(tick_rise), 32'd0);
        chk("rst_tick_fall", 32'(tick_fall), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_lost", 32'(clk_lost), 32'd0);
        @(negedge clk);
        drive_en = 1'b0; clk_div_in = 1'b0; ph = 0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        drive_en = 1'b1;

        // Half-period 2: latency, first measurement and lock.
        wait_rise();
        chk("tick_latency", 32'(dut_last_rise - in_rise_edge), 32'(LAT));
        chk("rise1_valid", 32'(period_valid), 32'd0);
        wait_rise();
        chk("rise2_period", 32'(period), 32'd4);
        chk("rise2_valid", 32'(period_valid), 32'd1);
        wait_rise();
        wait_rise();
        chk("rise4_locked", 32'(locked), 32'd0);
        wait_rise();
        chk("rise5_locked", 32'(locked), 32'd1);

        // Half-period 3 while locked.
        half_next = 3;
        for (int i = 0; i < 4 && period == 4; i++) wait_rise();
        chk("chg_period", 32'(period), 32'd6);
        chk("chg_locked", 32'(locked), 32'd0);
        wait_rise();
        wait_rise();
        chk("chg_rise3_locked", 32'(locked), 32'd0);
        wait_rise();
        chk("chg_rise4_locked", 32'(locked), 32'd1);

        // Back to period 4, then lose the clock.
        half_next = 2;
        for (int i = 0; i < 16 && !(locked && period == 4); i++) wait_rise();
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_period", 32'(period), 32'd4);
        stop_low = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #2;
            got = clk_lost;
        end
        chk("lost_seen", 32'(got), 32'd1);
        chk("lost_delay", 32'(edge_n - dut_last_rise), 32'(TIMEOUT));
        chk("lost_locked", 32'(locked), 32'd0);
        chk("lost_valid", 32'(period_valid), 32'd0);
        chk("lost_period", 32'(period), 32'd4);

        stop_low = 1'b0;
        wait_rise();
        chk("resume1_lost", 32'(clk_lost), 32'd0);
        chk("resume1_valid", 32'(period_valid), 32'd0);
        wait_rise();
        chk("resume2_valid", 32'(period_valid), 32'd1);
        chk("resume2_period", 32'(period), 32'd4);

        // Rise lands on the cycle cnt reaches TIMEOUT.
        half_next = TIMEOUT / 2;
        for (int i = 0; i < 4 && period == 4; i++) wait_rise();
        chk("edge_to_period", 32'(period), 32'(TIMEOUT));
        chk("edge_to_lost", 32'(clk_lost), 32'd0);
        half_next = 2;
        wait_rise();
        wait_rise();
        wait_rise();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
